// File: rtl/rrarbiter_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
interface rrarbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IW = $clog2(N);

  logic          FixedPriority;
  logic [N-1:0]  Req;
  logic          Done;
  logic [N-1:0]  Grant;
  logic          GrantValid;
  logic [IW-1:0] GrantIdx;

  modport master (
    output FixedPriority, Req, Done,
    input  Grant, GrantValid, GrantIdx
  );

  modport slave (
    input  FixedPriority, Req, Done,
    output Grant, GrantValid, GrantIdx
  );
endinterface

// File: rtl/rrarbiter.sv
// N-way round-robin / fixed-priority arbiter with a registered one-hot grant
// that stays locked until the grantee signals Done.
module rrarbiter #(
  parameter int unsigned N = 4
) (
  input  logic        clk,
  input  logic        reset,
  rrarbiter_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [IW-1:0] next_ptr_c;
  logic [IW-1:0] start_c;
  logic [N-1:0]  win_c;

  // Rotate right by start, isolate lowest set bit, rotate back.
  function automatic logic [N-1:0] arb(input logic [N-1:0] req,
                                       input logic [IW-1:0] start);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [N-1:0]   one;
    dbl = {req, req} >> start;
    rot = dbl[N-1:0];
    one = rot & (~rot + N'(1));
    dbl = {one, one} << start;
    return dbl[2*N-1:N];
  endfunction

  function automatic logic [IW-1:0] enc(input logic [N-1:0] onehot);
    logic [IW-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (onehot[i]) idx = IW'(i);
    end
    return idx;
  endfunction

  // Successor of the current grantee, wrapping at N-1 (N need not be a power of two).
  assign next_ptr_c = (idx_q == IW'(N - 1)) ? '0 : idx_q + IW'(1);

  // One shared arbiter: the start point depends on whether we rearbitrate after Done.
  assign start_c = bus.FixedPriority ? '0 :
                   ((state_q == BUSY) ? next_ptr_c : ptr_q);
  assign win_c   = arb(bus.Req, start_c);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (|bus.Req) begin
          grant_d = win_c;
          idx_d   = enc(win_c);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.Done) begin
          ptr_d = next_ptr_c;
          if (|bus.Req) begin
            grant_d = win_c;
            idx_d   = enc(win_c);
          end else begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.Grant      = grant_q;
  assign bus.GrantValid = (state_q == BUSY);
  assign bus.GrantIdx   = idx_q;

endmodule

// File: tb/tb_rrarbiter.sv
// Bench for rrarbiter: directed vector table followed by random traffic,
// both checked against a scan-based reference model.
module tb_rrarbiter;
  localparam int unsigned N = 4;

  logic clk;
  logic reset;

  rrarbiter_if #(.N(N)) bus ();

  rrarbiter #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       fp;
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
    logic       exp_valid;
    logic [1:0] exp_idx;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers.
  int         m_busy;
  int         m_idx;
  int         m_ptr;
  logic [3:0] m_grant;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // First requester found scanning start, start+1, ... modulo N; -1 if none.
  function automatic int scan(input logic [3:0] req, input int start);
    for (int k = 0; k < int'(N); k++) begin
      int j;
      j = (start + k) % int'(N);
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    if (reset) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_grant = '0;
    end else if (m_busy == 0) begin
      if (bus.Req != 4'b0) begin
        w = scan(bus.Req, bus.FixedPriority ? 0 : m_ptr);
        m_grant = 4'(1 << w);
        m_idx   = w;
        m_busy  = 1;
      end
    end else if (bus.Done) begin
      m_ptr = (m_idx + 1) % int'(N);
      w = scan(bus.Req, bus.FixedPriority ? 0 : m_ptr);
      if (w >= 0) begin
        m_grant = 4'(1 << w);
        m_idx   = w;
      end else begin
        m_grant = '0;
        m_busy  = 0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic fp, input logic [3:0] req,
                       input logic done);
    reset             = rst;
    bus.FixedPriority = fp;
    bus.Req           = req;
    bus.Done          = done;
  endtask

  // One clock: update the model at the edge, sample the DUT 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_grant", int'(bus.Grant), int'(m_grant));
    chk("model_valid", int'(bus.GrantValid), m_busy);
    chk("model_idx",   int'(bus.GrantIdx), m_idx);
  endtask

  task automatic add(input logic rst, input logic fp, input logic [3:0] req,
                     input logic done, input logic [3:0] g, input logic v,
                     input logic [1:0] i);
    vec_t t;
    t.rst = rst; t.fp = fp; t.req = req; t.done = done;
    t.exp_grant = g; t.exp_valid = v; t.exp_idx = i;
    vecs.push_back(t);
  endtask

  initial begin
    m_busy = 0; m_idx = 0; m_ptr = 0; m_grant = '0;
    drive(1'b1, 1'b0, 4'b1111, 1'b1);

    // rst fp req done -> grant valid idx
    add(1, 0, 4'b1111, 1, 4'b0000, 0, 0);   // reset, Req/Done ignored
    add(1, 0, 4'b1111, 1, 4'b0000, 0, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 0, 0);   // first cycle after deassert
    add(0, 0, 4'b1010, 0, 4'b0010, 1, 1);   // rotation from Ptr=0
    add(0, 0, 4'b1010, 1, 4'b1000, 1, 3);
    add(0, 0, 4'b1010, 1, 4'b0010, 1, 1);   // Ptr wrapped to 0
    add(0, 0, 4'b0000, 1, 4'b0000, 0, 1);   // release, idx holds
    add(1, 0, 4'b0000, 0, 4'b0000, 0, 0);
    add(0, 0, 4'b1111, 0, 4'b0001, 1, 0);   // back-to-back fairness
    add(0, 0, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 0, 4'b1111, 1, 4'b0100, 1, 2);
    add(0, 0, 4'b1111, 1, 4'b1000, 1, 3);
    add(0, 0, 4'b1111, 1, 4'b0001, 1, 0);
    add(0, 0, 4'b1111, 1, 4'b0010, 1, 1);
    add(0, 0, 4'b1111, 1, 4'b0100, 1, 2);
    for (int k = 0; k < 5; k++)
      add(0, 0, 4'b0000, 0, 4'b0100, 1, 2); // lock despite Req withdrawal
    add(0, 0, 4'b0000, 1, 4'b0000, 0, 2);
    add(0, 1, 4'b1111, 0, 4'b0001, 1, 0);   // fixed priority
    add(0, 1, 4'b1111, 1, 4'b0001, 1, 0);
    add(0, 1, 4'b1111, 1, 4'b0001, 1, 0);
    add(0, 0, 4'b1111, 1, 4'b0010, 1, 1);   // rotating resumes after grantee 0
    add(0, 0, 4'b1111, 1, 4'b0100, 1, 2);
    add(1, 0, 4'b1111, 0, 4'b0000, 0, 0);   // reset mid-grant
    add(0, 0, 4'b1100, 0, 4'b0100, 1, 2);
    add(0, 0, 4'b1100, 1, 4'b1000, 1, 3);
    add(0, 0, 4'b0001, 1, 4'b0001, 1, 0);   // wrap from idx 3
    add(0, 0, 4'b0001, 1, 4'b0001, 1, 0);   // sole requester wins again
    add(0, 0, 4'b0011, 0, 4'b0001, 1, 0);
    add(0, 0, 4'b0011, 1, 4'b0010, 1, 1);   // previous grantee now lowest
    add(0, 0, 4'b0000, 1, 4'b0000, 0, 1);

    #1;
    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].fp, vecs[n].req, vecs[n].done);
      step();
      chk($sformatf("vec%0d_grant", n), int'(bus.Grant), int'(vecs[n].exp_grant));
      chk($sformatf("vec%0d_valid", n), int'(bus.GrantValid), int'(vecs[n].exp_valid));
      chk($sformatf("vec%0d_idx", n),   int'(bus.GrantIdx), int'(vecs[n].exp_idx));
    end

    // Random traffic: occasional reset, sticky FixedPriority, biased Done.
    begin
      logic fp;
      fp = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 31) == 0) fp = ~fp;
        drive(($urandom_range(0, 99) == 0), fp, 4'($urandom_range(0, 15)),
              ($urandom_range(0, 2) != 0));
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rrarbiter.md
# rrarbiter

Parametrised N-way arbiter with rotating (round-robin) or fixed least-significant-first priority, registered one-hot grant, and grant locking until the granted transfer signals completion. It generalises the combinational lsb-first one-hot priority circuit into a stateful, fair arbiter. It sits in front of shared resources such as a bus, a cache port or a shared functional unit, where multiple requesters contend and a grant must stay stable for a multi-cycle transfer.

## Interface
- N, default 4: number of requesters; N >= 2.
- IW, default $clog2(N): width of the encoded grant index. Derived; do not override.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- FixedPriority  in  1  1 = priority always starts at index 0 (lsb-first); 0 = rotating priority starting at Ptr.
- Req  in  N  request vector, one bit per requester; level-sensitive, sampled every cycle.
- Done  in  1  current granted transfer completes this cycle; ignored when GrantValid = 0.
- Grant  out  N  registered one-hot grant; all zeros when GrantValid = 0.
- GrantValid  out  1  registered; 1 while a grant is held (BUSY).
- GrantIdx  out  IW  registered binary index of the set Grant bit; holds its last value when GrantValid = 0.

## Operation
- Internal state: FSM {IDLE, BUSY}; Ptr (IW bits, highest-priority index); GrantReg (N); GrantIdx (IW).
- Arbitration function Arb(Req, Start): one-hot of the first set bit of Req scanning Start, Start+1, ..., N-1, 0, ..., Start-1 (modulo N). All-zero if Req = 0. Built as rotate-right by Start, lsb-first one-hot priority, rotate-left by Start.
- Start = 0 when FixedPriority = 1; otherwise Start = Ptr.
- IDLE: if |Req, GrantReg <= Arb(Req, Start), GrantIdx <= encoded index, go BUSY. Else stay IDLE, Grant = 0.
- BUSY, Done = 0: Grant, GrantIdx held unchanged regardless of Req (lock). Withdrawal of the grantee's Req does not release the grant.
- BUSY, Done = 1: Ptr <= (GrantIdx + 1) mod N. Rearbitrate in the same cycle with Start = (FixedPriority ? 0 : (GrantIdx + 1) mod N). If winner exists, load it, stay BUSY (zero-bubble back-to-back). Else Grant <= 0, go IDLE.
- The previous grantee is eligible for rearbitration at lowest priority; it wins again only if no other requester is active.
- Ptr updates on every Done in BUSY regardless of FixedPriority, so switching to rotating mode resumes after the last grantee.
- FixedPriority is sampled only at arbitration instants; changing it mid-grant does not affect the held grant.
- Grant is always one-hot or zero; GrantValid = |Grant.

## Timing
- Reset (reset = 1 at an edge): next cycle Grant = 0, GrantValid = 0, GrantIdx = 0, Ptr = 0, FSM = IDLE. Reset overrides Done and Req, including mid-grant.
- Request-to-grant latency: 1 cycle (Req seen in IDLE at edge k -> Grant valid after edge k).
- Done-to-next-grant latency: 0 bubble cycles; the next grant appears in the cycle following Done.
- Sustained throughput: one grant per cycle when Done asserted every cycle.
- No combinational path from Req or Done to any output; all outputs are flops.
- Wrap-around: GrantIdx = N-1 with Done -> Ptr = 0.

## Test plan
- Reset: assert reset 2 cycles with Req = 1111, Done = 1 -> Grant = 0000, GrantValid = 0, GrantIdx = 0 throughout and on the first cycle after deassert.
- Rotation from IDLE, N = 4, FixedPriority = 0, Ptr = 0: Req = 1010 -> next cycle Grant = 0010, GrantIdx = 1; pulse Done -> next cycle Grant = 1000, GrantIdx = 3; Done again with Req = 1010 -> Grant = 0010 (Ptr wrapped to 0).
- Back-to-back fairness: Req = 1111, Done = 1 every cycle -> Grant sequence 0001, 0010, 0100, 1000, 0001, GrantValid constantly 1.
- Lock: Grant = 0100 held, Req drops to 0000 for 5 cycles with Done = 0 -> Grant stays 0100; Done = 1 with Req = 0000 -> next cycle Grant = 0000, GrantValid = 0.
- Fixed mode: FixedPriority = 1, Req = 1111, Done every cycle -> Grant = 0001 every cycle; switch FixedPriority = 0 -> next grant 0010 (Ptr = 1).
- Reset mid-grant: Grant = 0100, assert reset 1 cycle -> Grant = 0000; then Req = 1100 -> next cycle Grant = 0100, GrantIdx = 2 (Ptr = 0).
